pulse_window_checker: RTL and testbench
=======================================

// Module: pulse_window_checker
// PURPOSE
//  Receive-side monitor for the periodic window pulse made by the frame counter (out high in a fixed window of each frame).
//  Measures the pulse period and high width on every rising edge and compares both with expected values.
//  Asserts lock after LOCK_CNT consecutive matching frames. Flags and counts mismatches and dropouts.
//  Sits on the consumer side of the pulse link and feeds status LEDs and self-test logic.
// PARAMETERS
//  CNT_W    8   width of measurement counters and err_cnt
//  PERIOD   21  expected cycles between rising edges (frame counter runs 0..20)
//  HIGH_LEN 6   expected high cycles per frame
//  LOCK_CNT 3   consecutive matching measurements needed to assert lock
// PORTS
//  clk          in   1      system clock, 50MHz
//  rst          in   1      synchronous reset, active-high
//  pulse_in     in   1      monitored pulse train
//  lock         out  1      high while the pulse train matches PERIOD/HIGH_LEN
//  meas_valid   out  1      1-cycle strobe: period_meas and width_meas updated
//  period_meas  out  CNT_W  last measured period, in cycles
//  width_meas   out  CNT_W  last measured high width, in cycles
//  err          out  1      1-cycle strobe: mismatch or timeout while locked
//  err_cnt      out  CNT_W  saturating count of err strobes
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high. Ports clk, rst.
//  - While rst=1 at a clk edge, all registers and outputs clear to 0 and state goes to IDLE.
//    A reset mid-frame drops lock and discards any partial measurement.
//  - p = sampled pulse, p_d = p delayed by 1 cycle. rise = p & ~p_d.
//  - per_cnt: loads 1 on rise, otherwise increments and saturates at 2^CNT_W-1.
//  - wid_cnt: loads 1 on rise, otherwise increments when p=1 and saturates.
//  - Example: rises at t0 and t0+21 with 6 high cycles -> at the second rise per_cnt=21, wid_cnt=6.
//  - FSM states: IDLE, MEASURE, LOCKED.
//    IDLE: first rise loads the counters and goes to MEASURE. No measurement is issued.
//    MEASURE or LOCKED, on rise:
//      period_meas<=per_cnt; width_meas<=wid_cnt; meas_valid=1 in the next cycle.
//      match = (per_cnt==PERIOD) && (wid_cnt==HIGH_LEN).
//    MEASURE: match increments match_cnt. Reaching LOCK_CNT goes to LOCKED with lock=1.
//      A mismatch clears match_cnt.
//    LOCKED: a match stays LOCKED. A mismatch pulses err, clears lock and match_cnt, and goes to MEASURE.
//    Timeout: per_cnt saturated with no rise goes to IDLE (pulse stuck high or low).
//      From LOCKED this also pulses err and clears lock.
//  - When rise and saturation happen in the same cycle, rise wins.
//  - All outputs are registered. Flags update 1 cycle after the rise cycle.
//    lock rises together with the LOCK_CNT-th meas_valid.
//  - err_cnt increments on each err and saturates at 2^CNT_W-1. It clears only on rst.
//  - err never asserts outside LOCKED. Mismatches in MEASURE only reset match_cnt.
// CONFIGURATION
//  INPUT_SYNC_EN defined:
//    pulse_in passes through a 2-flop synchronizer before p.
//    All responses are delayed by 2 extra cycles. For asynchronous sources.
//  INPUT_SYNC_EN undefined:
//    p = pulse_in sampled directly. pulse_in must be synchronous to clk.
// TESTING (INPUT_SYNC_EN undefined unless stated)
//  1. Nominal train, period 21, high 6:
//     -> meas_valid every 21 cycles with period_meas=21 and width_meas=6.
//     -> lock=1 one cycle after the 4th rise. err stays 0.
//  2. Locked, then one frame with 7 high cycles:
//     -> width_meas=7, err 1-cycle pulse, err_cnt=1, lock=0.
//     -> lock returns after 3 further good frames.
//  3. Locked, then one frame with period 22:
//     -> period_meas=22, err pulse, err_cnt increments, state MEASURE.
//  4. Locked, then pulse_in held low (and separately held high) for 300 cycles:
//     -> err pulse once, when per_cnt hits 255. lock=0, state IDLE, no further err.
//  5. rst=1 for 1 cycle mid-frame while locked:
//     -> all outputs 0 next cycle, err_cnt=0.
//     -> relock requires 1+LOCK_CNT rises.
//  6. INPUT_SYNC_EN defined, nominal train:
//     -> same values as test 1, every strobe 2 cycles later.

Source files
------------

// File: rtl/pulse_window_checker.sv
// pulse_window_checker
// Receive-side monitor for a periodic window pulse. Measures the period and
// high width between rising edges, locks after LOCK_CNT consecutive matching
// frames, and flags/counts mismatches and dropouts that occur while locked.
// Optional build macro: INPUT_SYNC_EN adds a 2-flop synchronizer on pulse_in
// for asynchronous sources (all responses then shift 2 cycles later).
module pulse_window_checker #(
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 21,
  parameter int HIGH_LEN = 6,
  parameter int LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             lock,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] width_meas,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               MC_W     = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] HIGH_C   = CNT_W'(HIGH_LEN);
  localparam logic [MC_W-1:0]  LOCK_M1  = MC_W'(LOCK_CNT - 1);
  localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             p;
  logic             p_d;
  logic             rise;
  logic             sat;
  logic             match;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] wid_cnt;
  logic [MC_W-1:0]  match_cnt;
  logic [MC_W-1:0]  match_cnt_nxt;
  logic             meas_nxt;
  logic             err_nxt;

`ifdef INPUT_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer so an asynchronous pulse source cannot go metastable into the edge detector
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pulse_in};
    end
  end

  assign p = sync_q[1];
`else
  assign p = pulse_in;
`endif

  assign rise  = p & ~p_d;
  assign sat   = (per_cnt == CNT_MAX);
  assign match = (per_cnt == PERIOD_C) && (wid_cnt == HIGH_C);

  // Edge history plus period/width counters; a rise restarts both at 1 so the rise cycle itself counts
  always_ff @(posedge clk) begin
    if (rst) begin
      p_d     <= 1'b0;
      per_cnt <= '0;
      wid_cnt <= '0;
    end else begin
      p_d <= p;
      if (rise) begin
        per_cnt <= CNT_ONE;
        wid_cnt <= CNT_ONE;
      end else begin
        if (!sat) begin
          per_cnt <= per_cnt + CNT_ONE;
        end
        if (p && (wid_cnt != CNT_MAX)) begin
          wid_cnt <= wid_cnt + CNT_ONE;
        end
      end
    end
  end

  // State and consecutive-match register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_cnt_nxt;
    end
  end

  // Next-state decode: a rise always takes priority over a saturated period counter
  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt     = MEASURE;
          match_cnt_nxt = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          if (match) begin
            match_cnt_nxt = match_cnt + MC_ONE;
            if (match_cnt == LOCK_M1) begin
              state_nxt = LOCKED;
            end
          end else begin
            match_cnt_nxt = '0;
          end
        end else if (sat) begin
          state_nxt     = IDLE;
          match_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!match) begin
            state_nxt     = MEASURE;
            match_cnt_nxt = '0;
          end
        end else if (sat) begin
          state_nxt     = IDLE;
          match_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        match_cnt_nxt = '0;
      end
    endcase
  end

  // Output decode: measurements only once a reference rise exists, errors only while locked
  always_comb begin
    meas_nxt = rise && (state != IDLE);
    err_nxt  = (state == LOCKED) && ((rise && !match) || (!rise && sat));
  end

  // Registered outputs so every flag appears one cycle after the cycle that caused it
  always_ff @(posedge clk) begin
    if (rst) begin
      lock        <= 1'b0;
      meas_valid  <= 1'b0;
      period_meas <= '0;
      width_meas  <= '0;
      err         <= 1'b0;
      err_cnt     <= '0;
    end else begin
      lock       <= (state_nxt == LOCKED);
      meas_valid <= meas_nxt;
      err        <= err_nxt;
      if (meas_nxt) begin
        period_meas <= per_cnt;
        width_meas  <= wid_cnt;
      end
      if (err_nxt && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pulse_window_checker.sv
// tb_pulse_window_checker
// Directed frames, bad frames, dropouts and resets against a frame-level model
// of pulse_window_checker. Honours INPUT_SYNC_EN when the same macro is defined.
module tb_pulse_window_checker;

  localparam int CNT_W    = 8;
  localparam int PERIOD   = 21;
  localparam int HIGH_LEN = 6;
  localparam int LOCK_CNT = 3;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pulse_in = 1'b0;
  logic             lock;
  logic             meas_valid;
  logic [CNT_W-1:0] period_meas;
  logic [CNT_W-1:0] width_meas;
  logic             err;
  logic [CNT_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // model state
  int age = 0;
  int hi = 0;
  int streak = 0;
  bit engaged = 1'b0;
  bit m_pd = 1'b0;
  bit s0 = 1'b0;
  bit s1 = 1'b0;
  int exp_lock = 0;
  int exp_meas = 0;
  int exp_per = 0;
  int exp_wid = 0;
  int exp_err = 0;
  int exp_errs = 0;

  pulse_window_checker #(
    .CNT_W(CNT_W), .PERIOD(PERIOD), .HIGH_LEN(HIGH_LEN), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pulse_in(pulse_in),
    .lock(lock),
    .meas_valid(meas_valid),
    .period_meas(period_meas),
    .width_meas(width_meas),
    .err(err),
    .err_cnt(err_cnt)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit level, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      pulse_in = level;
    end
  endtask

  task automatic sendFrame(input int high_len, input int period);
    applyStimulus(1'b1, high_len);
    applyStimulus(1'b0, period - high_len);
  endtask

  task automatic sendGood(input int n);
    for (int i = 0; i < n; i++) sendFrame(HIGH_LEN, PERIOD);
  endtask

  // Frame-level model: time since the last rise, high cycles since it, and a run of good frames
  always @(posedge clk) begin
    bit pv;
    bit r;
    int per;
    int wid;
    if (rst) begin
      age = 0; hi = 0; streak = 0; engaged = 0; m_pd = 0; s0 = 0; s1 = 0;
      exp_lock = 0; exp_meas = 0; exp_per = 0; exp_wid = 0; exp_err = 0; exp_errs = 0;
    end else begin
`ifdef INPUT_SYNC_EN
      pv = s1;
      s1 = s0;
      s0 = pulse_in;
`else
      pv = pulse_in;
`endif
      r = pv && !m_pd;
      per = (age > SAT) ? SAT : age;
      wid = (hi > SAT) ? SAT : hi;
      exp_meas = 0;
      exp_err = 0;
      if (r) begin
        if (engaged) begin
          exp_meas = 1;
          exp_per = per;
          exp_wid = wid;
          if (per == PERIOD && wid == HIGH_LEN) begin
            streak++;
          end else begin
            if (streak >= LOCK_CNT) exp_err = 1;
            streak = 0;
          end
        end
        engaged = 1;
        age = 1;
        hi = 1;
      end else begin
        if (engaged && age >= SAT) begin
          if (streak >= LOCK_CNT) exp_err = 1;
          engaged = 0;
          streak = 0;
        end
        age++;
        if (pv) hi++;
      end
      if (exp_err == 1 && exp_errs < SAT) exp_errs++;
      exp_lock = (streak >= LOCK_CNT) ? 1 : 0;
      m_pd = pv;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("lock", int'(lock), exp_lock);
      checkOutput("meas_valid", int'(meas_valid), exp_meas);
      checkOutput("period_meas", int'(period_meas), exp_per);
      checkOutput("width_meas", int'(width_meas), exp_wid);
      checkOutput("err", int'(err), exp_err);
      checkOutput("err_cnt", int'(err_cnt), exp_errs);
    end
  end

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    pulse_in = 1'b0;
    @(negedge clk);
    checking = 1'b1;
    @(negedge clk);
    checkOutput("reset_lock", int'(lock), 0);
    checkOutput("reset_err_cnt", int'(err_cnt), 0);
    rst = 1'b0;

    // nominal train: lock follows the 4th rise
    sendGood(3);
    checkOutput("nominal_lock_after3", int'(lock), 0);
    sendGood(1);
    checkOutput("nominal_lock_after4", int'(lock), 1);
    checkOutput("nominal_period", int'(period_meas), 21);
    checkOutput("nominal_width", int'(width_meas), 6);
    sendGood(1);

    // one wide frame while locked
    sendFrame(7, PERIOD);
    sendGood(1);
    checkOutput("wide_width", int'(width_meas), 7);
    checkOutput("wide_err_cnt", int'(err_cnt), 1);
    checkOutput("wide_lock", int'(lock), 0);
    sendGood(2);
    checkOutput("wide_relock_pending", int'(lock), 0);
    sendGood(1);
    checkOutput("wide_relock", int'(lock), 1);

    // one long frame while locked
    sendFrame(HIGH_LEN, 22);
    sendGood(1);
    checkOutput("long_period", int'(period_meas), 22);
    checkOutput("long_err_cnt", int'(err_cnt), 2);
    checkOutput("long_lock", int'(lock), 0);
    sendGood(3);
    checkOutput("long_relock", int'(lock), 1);

    // dropout stuck low
    applyStimulus(1'b0, 300);
    checkOutput("stuck_low_err_cnt", int'(err_cnt), 3);
    checkOutput("stuck_low_lock", int'(lock), 0);
    sendGood(5);
    checkOutput("relock_after_low", int'(lock), 1);

    // dropout stuck high
    applyStimulus(1'b1, 300);
    applyStimulus(1'b0, 10);
    checkOutput("stuck_high_err_cnt", int'(err_cnt), 4);
    checkOutput("stuck_high_lock", int'(lock), 0);
    sendGood(5);

    // reset mid-frame while locked, during the low phase
    applyStimulus(1'b1, HIGH_LEN);
    applyStimulus(1'b0, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_lock", int'(lock), 0);
    checkOutput("midreset_err_cnt", int'(err_cnt), 0);
    checkOutput("midreset_period", int'(period_meas), 0);
    applyStimulus(1'b0, 10);
    sendGood(3);
    checkOutput("midreset_relock_pending", int'(lock), 0);
    sendGood(1);
    checkOutput("midreset_relock", int'(lock), 1);

    // rise coinciding with a saturated period counter: the rise is measured
    sendFrame(HIGH_LEN, SAT);
    sendGood(1);
    checkOutput("sat_rise_period", int'(period_meas), 255);
    checkOutput("sat_rise_err_cnt", int'(err_cnt), 1);
    sendGood(3);
    checkOutput("sat_rise_relock", int'(lock), 1);

    // drive err_cnt into saturation
    for (int k = 0; k < 258; k++) begin
      sendFrame(7, PERIOD);
      sendGood(3);
    end
    sendGood(1);
    checkOutput("err_cnt_saturated", int'(err_cnt), 255);

    checking = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
